// File: rtl/time_counter.sv
// time_counter -- real-time-of-day counter for the clock design.
//
// Divides the system clock down to a one-second tick and keeps
// hours:minutes:seconds as six BCD digits, each of which feeds a
// BCD-to-7-segment decoder directly (every digit is always 0-9).
// Single-cycle pulses step the minutes and the hours.
//
// Build option:
//   TIME_COUNTER_12H_EN  defined   -> hours run 12,01..11,12; pm toggles on
//                                     every 11->12 step; reset time 12:00:00.
//                        undefined -> hours run 00..23; pm tied to 0.
//
// Parameters:
//   TICKS_PER_SEC          clock cycles per second (minimum 1)
// Ports:
//   time_counter_clk       system clock, rising edge
//   time_counter_rst       asynchronous active-high reset
//   time_counter_en        run enable; 0 freezes prescaler and time
//   time_counter_inc_min   pulse: minutes +1 mod 60, clears seconds/prescaler
//   time_counter_inc_hour  pulse: hours +1 with the normal hour wrap
//   time_counter_sec_u/_t  seconds units / tens digit
//   time_counter_min_u/_t  minutes units / tens digit
//   time_counter_hour_u/_t hours units / tens digit
//   time_counter_sec_pulse one-cycle strobe on each seconds update
//   time_counter_pm        PM flag (12 h build only)
module time_counter #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       time_counter_clk,
  input  logic       time_counter_rst,
  input  logic       time_counter_en,
  input  logic       time_counter_inc_min,
  input  logic       time_counter_inc_hour,
  output logic [3:0] time_counter_sec_u,
  output logic [3:0] time_counter_sec_t,
  output logic [3:0] time_counter_min_u,
  output logic [3:0] time_counter_min_t,
  output logic [3:0] time_counter_hour_u,
  output logic [3:0] time_counter_hour_t,
  output logic       time_counter_sec_pulse,
  output logic       time_counter_pm
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

`ifdef TIME_COUNTER_12H_EN
  localparam logic [3:0] HOUR_RST_T = 4'd1;
  localparam logic [3:0] HOUR_RST_U = 4'd2;
`else
  localparam logic [3:0] HOUR_RST_T = 4'd0;
  localparam logic [3:0] HOUR_RST_U = 4'd0;
`endif

  // Increment a 00..59 BCD pair; returns {carry_out, tens, units}.
  function automatic logic [8:0] bcd60_inc(input logic [3:0] t, input logic [3:0] u);
    if (u == 4'd9) begin
      if (t == 4'd5) return {1'b1, 4'd0, 4'd0};
      else           return {1'b0, t + 4'd1, 4'd0};
    end
    return {1'b0, t, u + 4'd1};
  endfunction

  // Increment the hour pair; returns {pm_toggle, tens, units}.
  function automatic logic [8:0] hour_inc(input logic [3:0] t, input logic [3:0] u);
`ifdef TIME_COUNTER_12H_EN
    if (t == 4'd1 && u == 4'd2)      return {1'b0, 4'd0, 4'd1};
    else if (t == 4'd1 && u == 4'd1) return {1'b1, 4'd1, 4'd2};
`else
    if (t == 4'd2 && u == 4'd3)      return {1'b0, 4'd0, 4'd0};
`endif
    else if (u == 4'd9)              return {1'b0, t + 4'd1, 4'd0};
    return {1'b0, t, u + 4'd1};
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sec_u_q, sec_u_d, sec_t_q, sec_t_d;
  logic [3:0]    min_u_q, min_u_d, min_t_q, min_t_d;
  logic [3:0]    hour_u_q, hour_u_d, hour_t_q, hour_t_d;
  logic          pm_q, pm_d;
  logic          sec_pulse_q, sec_pulse_d;
  logic          tick;
  logic [8:0]    sec_nx, min_nx, hour_nx;

  always_comb begin
    tick        = time_counter_en && (presc_q == PRESC_LAST);
    sec_nx      = bcd60_inc(sec_t_q, sec_u_q);
    min_nx      = bcd60_inc(min_t_q, min_u_q);
    hour_nx     = hour_inc(hour_t_q, hour_u_q);
    presc_d     = presc_q;
    sec_u_d     = sec_u_q;
    sec_t_d     = sec_t_q;
    min_u_d     = min_u_q;
    min_t_d     = min_t_q;
    hour_u_d    = hour_u_q;
    hour_t_d    = hour_t_q;
    pm_d        = pm_q;
    sec_pulse_d = 1'b0;

    if (time_counter_inc_min) begin
      // Minute set restarts the current minute: no carry into hours.
      {min_t_d, min_u_d} = min_nx[7:0];
      sec_t_d            = 4'd0;
      sec_u_d            = 4'd0;
      presc_d            = '0;
      sec_pulse_d        = 1'b1;
    end else begin
      // A tick that loses to inc_hour is still consumed by the prescaler.
      if (time_counter_en) presc_d = tick ? '0 : presc_q + PW'(1);
      if (time_counter_inc_hour) begin
        {hour_t_d, hour_u_d} = hour_nx[7:0];
        pm_d                 = pm_q ^ hour_nx[8];
      end else if (tick) begin
        {sec_t_d, sec_u_d} = sec_nx[7:0];
        sec_pulse_d        = 1'b1;
        if (sec_nx[8]) begin
          {min_t_d, min_u_d} = min_nx[7:0];
          if (min_nx[8]) begin
            {hour_t_d, hour_u_d} = hour_nx[7:0];
            pm_d                 = pm_q ^ hour_nx[8];
          end
        end
      end
    end
  end

  always_ff @(posedge time_counter_clk or posedge time_counter_rst) begin
    if (time_counter_rst) begin
      presc_q     <= '0;
      sec_u_q     <= 4'd0;
      sec_t_q     <= 4'd0;
      min_u_q     <= 4'd0;
      min_t_q     <= 4'd0;
      hour_u_q    <= HOUR_RST_U;
      hour_t_q    <= HOUR_RST_T;
      pm_q        <= 1'b0;
      sec_pulse_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sec_u_q     <= sec_u_d;
      sec_t_q     <= sec_t_d;
      min_u_q     <= min_u_d;
      min_t_q     <= min_t_d;
      hour_u_q    <= hour_u_d;
      hour_t_q    <= hour_t_d;
      pm_q        <= pm_d;
      sec_pulse_q <= sec_pulse_d;
    end
  end

  assign time_counter_sec_u     = sec_u_q;
  assign time_counter_sec_t     = sec_t_q;
  assign time_counter_min_u     = min_u_q;
  assign time_counter_min_t     = min_t_q;
  assign time_counter_hour_u    = hour_u_q;
  assign time_counter_hour_t    = hour_t_q;
  assign time_counter_sec_pulse = sec_pulse_q;
  assign time_counter_pm        = pm_q;

endmodule

// File: tb/tb_time_counter.sv
// Directed testbench for time_counter with TICKS_PER_SEC = 4.
// Time is compared as a 24-bit word {hh,mm,ss} whose hex spelling equals the
// BCD clock reading (e.g. 24'h235959 is 23:59:59).
module tb_time_counter;
  localparam int TPS = 4;

`ifdef TIME_COUNTER_12H_EN
  localparam logic [7:0] RST_H   = 8'h12;
  localparam logic [7:0] PRE_H   = 8'h11;
  localparam logic [7:0] WRAP_H  = 8'h12;
  localparam logic       WRAP_PM = 1'b1;
  localparam int         PRE_INC = 10;
`else
  localparam logic [7:0] RST_H   = 8'h00;
  localparam logic [7:0] PRE_H   = 8'h23;
  localparam logic [7:0] WRAP_H  = 8'h00;
  localparam logic       WRAP_PM = 1'b0;
  localparam int         PRE_INC = 22;
`endif

  logic       clk = 1'b0;
  logic       rst, en, inc_min, inc_hour;
  logic [3:0] sec_u, sec_t, min_u, min_t, hour_u, hour_t;
  logic       sec_pulse, pm;
  logic [23:0] now;

  int n_cmp = 0;
  int n_err = 0;

  time_counter #(.TICKS_PER_SEC(TPS)) dut (
    .time_counter_clk      (clk),
    .time_counter_rst      (rst),
    .time_counter_en       (en),
    .time_counter_inc_min  (inc_min),
    .time_counter_inc_hour (inc_hour),
    .time_counter_sec_u    (sec_u),
    .time_counter_sec_t    (sec_t),
    .time_counter_min_u    (min_u),
    .time_counter_min_t    (min_t),
    .time_counter_hour_u   (hour_u),
    .time_counter_hour_t   (hour_t),
    .time_counter_sec_pulse(sec_pulse),
    .time_counter_pm       (pm)
  );

  always #5 clk = ~clk;

  assign now = {hour_t, hour_u, min_t, min_u, sec_t, sec_u};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_min(input int n);
    for (int i = 0; i < n; i++) begin
      inc_min = 1'b1;
      step();
      inc_min = 1'b0;
      chk("inc_min_pulse", 32'(sec_pulse), 32'd1);
    end
  endtask

  task automatic pulse_hour(input int n);
    for (int i = 0; i < n; i++) begin
      inc_hour = 1'b1;
      step();
      inc_hour = 1'b0;
      chk("inc_hour_nopulse", 32'(sec_pulse), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
    steps(2);
    chk("rst_time",  32'(now),       32'({RST_H, 16'h0000}));
    chk("rst_pulse", 32'(sec_pulse), 32'd0);
    chk("rst_pm",    32'(pm),        32'd0);

    // First second lands on the 4th enabled edge.
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pre_tick_pulse", 32'(sec_pulse), 32'd0);
      chk("pre_tick_time",  32'(now),       32'({RST_H, 16'h0000}));
    end
    step();
    chk("first_tick_time",  32'(now),       32'({RST_H, 16'h0001}));
    chk("first_tick_pulse", 32'(sec_pulse), 32'd1);
    step();
    chk("pulse_one_cycle",  32'(sec_pulse), 32'd0);

    // Build 00:05:37 with prescaler at 2, then inc_min.
    en = 1'b0;
    pulse_min(5);
    chk("min_preload", 32'(now), 32'({RST_H, 16'h0500}));
    en = 1'b1;
    steps(37 * TPS);
    chk("at_0537", 32'(now), 32'({RST_H, 16'h0537}));
    steps(2);
    chk("at_0537_p2", 32'(now), 32'({RST_H, 16'h0537}));
    inc_min = 1'b1; step(); inc_min = 1'b0;
    chk("inc_min_time",  32'(now),       32'({RST_H, 16'h0600}));
    chk("inc_min_pulse", 32'(sec_pulse), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("presc_cleared_nopulse", 32'(sec_pulse), 32'd0);
    end
    chk("presc_cleared_time", 32'(now), 32'({RST_H, 16'h0600}));
    step();
    chk("after_clear_tick", 32'(now),       32'({RST_H, 16'h0601}));
    chk("after_clear_pulse", 32'(sec_pulse), 32'd1);

    // Minute wrap 59 -> 00 without carry into hours.
    en = 1'b0;
    pulse_min(53);
    chk("min_59", 32'(now), 32'({RST_H, 16'h5900}));
    pulse_min(1);
    chk("min_wrap_nocarry", 32'(now), 32'({RST_H, 16'h0000}));

    // inc_min and tick in the same cycle at 00:00:58.
    en = 1'b1;
    steps(58 * TPS);
    chk("at_0058", 32'(now), 32'({RST_H, 16'h0058}));
    steps(TPS - 1);
    inc_min = 1'b1; step(); inc_min = 1'b0;
    chk("min_beats_tick", 32'(now),       32'({RST_H, 16'h0100}));
    chk("min_beats_pulse", 32'(sec_pulse), 32'd1);
    steps(TPS - 1);
    chk("no_extra_second", 32'(now), 32'({RST_H, 16'h0100}));
    step();
    chk("next_second", 32'(now), 32'({RST_H, 16'h0101}));

    // inc_hour and tick in the same cycle: tick discarded but consumed.
    steps(TPS - 1);
    inc_hour = 1'b1; step(); inc_hour = 1'b0;
    chk("hour_beats_tick",  32'(now),       32'h010101);
    chk("hour_beats_pulse", 32'(sec_pulse), 32'd0);
    chk("hour_beats_pm",    32'(pm),        32'd0);
    steps(TPS - 1);
    chk("tick_consumed", 32'(now), 32'h010101);
    step();
    chk("tick_after_consume", 32'(now), 32'h010102);

    // en=0 freezes prescaler and digits.
    steps(2);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("freeze_nopulse", 32'(sec_pulse), 32'd0);
    end
    chk("freeze_time", 32'(now), 32'h010102);
    en = 1'b1;
    step();
    chk("resume_presc_held", 32'(sec_pulse), 32'd0);
    step();
    chk("resume_tick",  32'(now),       32'h010103);
    chk("resume_pulse", 32'(sec_pulse), 32'd1);

    // Preload to the last second before the hour wrap.
    en = 1'b0;
    pulse_hour(9);
    chk("hour_10", 32'(now), 32'h100103);
    pulse_hour(PRE_INC - 9);
    chk("hour_pre", 32'(now), 32'({PRE_H, 16'h0103}));
    pulse_min(58);
    en = 1'b1;
    steps(59 * TPS);
    chk("at_pre_wrap", 32'(now), 32'({PRE_H, 16'h5959}));
    chk("pm_before_wrap", 32'(pm), 32'd0);
    steps(TPS);
    chk("hour_wrap_time",  32'(now),       32'({WRAP_H, 16'h0000}));
    chk("hour_wrap_pulse", 32'(sec_pulse), 32'd1);
    chk("hour_wrap_pm",    32'(pm),        32'(WRAP_PM));
    en = 1'b0;
    pulse_hour(1);
    chk("inc_hour_after_wrap", 32'(now), 32'h010000);
    chk("inc_hour_pm_hold",    32'(pm),  32'(WRAP_PM));

    // Asynchronous reset mid-count at 05:43:21.
    pulse_hour(4);
    pulse_min(43);
    en = 1'b1;
    steps(21 * TPS);
    chk("at_054321", 32'(now), 32'h054321);
    steps(2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_time",  32'(now),       32'({RST_H, 16'h0000}));
    chk("async_rst_pulse", 32'(sec_pulse), 32'd0);
    chk("async_rst_pm",    32'(pm),        32'd0);
    step();
    rst = 1'b0;
    steps(TPS - 1);
    chk("post_rst_nopulse", 32'(sec_pulse), 32'd0);
    step();
    chk("post_rst_tick", 32'(now), 32'({RST_H, 16'h0001}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
